// File: rtl/write_back_stage_pipelined_pkg.sv
// Shared encodings for the write-back stage: result-source selects and load funct3 codes.
package riscv_wb_pkg;

    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;
    localparam int WB_PC4  = 2;
    localparam int WB_CSR  = 3;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

endpackage

// File: rtl/write_back_stage_pipelined_if.sv
// MEM->WB capture bus plus the register-file / retire outputs of the write-back stage.
interface write_back_stage_pipelined_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int WB_SEL_WIDTH   = 2,
    parameter int INSTRET_WIDTH  = 64
);
    localparam int OFF_W = $clog2(DATA_WIDTH / 8);

    logic                      STALL;
    logic                      FLUSH;
    logic                      VALID_IN;
    logic                      REG_WRITE_IN;
    logic [REG_ADDR_WIDTH-1:0] RD_ADDR_IN;
    logic [WB_SEL_WIDTH-1:0]   WB_SEL_IN;
    logic [2:0]                LOAD_TYPE_IN;
    logic [OFF_W-1:0]          BYTE_OFFSET_IN;
    logic [DATA_WIDTH-1:0]     ALU_RESULT_IN;
    logic [DATA_WIDTH-1:0]     MEM_DATA_IN;
    logic [DATA_WIDTH-1:0]     PC_PLUS_4_IN;
    logic [DATA_WIDTH-1:0]     CSR_DATA_IN;

    logic                      RD_WRITE_EN_OUT;
    logic [REG_ADDR_WIDTH-1:0] RD_ADDR_OUT;
    logic [DATA_WIDTH-1:0]     RD_DATA_OUT;
    logic                      VALID_OUT;
    logic                      RETIRE_OUT;
    logic                      MISALIGNED_OUT;
    logic [INSTRET_WIDTH-1:0]  INSTRET_OUT;

    modport master (
        output STALL, FLUSH, VALID_IN, REG_WRITE_IN, RD_ADDR_IN, WB_SEL_IN, LOAD_TYPE_IN,
               BYTE_OFFSET_IN, ALU_RESULT_IN, MEM_DATA_IN, PC_PLUS_4_IN, CSR_DATA_IN,
        input  RD_WRITE_EN_OUT, RD_ADDR_OUT, RD_DATA_OUT, VALID_OUT, RETIRE_OUT,
               MISALIGNED_OUT, INSTRET_OUT
    );

    modport slave (
        input  STALL, FLUSH, VALID_IN, REG_WRITE_IN, RD_ADDR_IN, WB_SEL_IN, LOAD_TYPE_IN,
               BYTE_OFFSET_IN, ALU_RESULT_IN, MEM_DATA_IN, PC_PLUS_4_IN, CSR_DATA_IN,
        output RD_WRITE_EN_OUT, RD_ADDR_OUT, RD_DATA_OUT, VALID_OUT, RETIRE_OUT,
               MISALIGNED_OUT, INSTRET_OUT
    );

endinterface

// File: rtl/write_back_stage_pipelined_aligner.sv
// Load-data aligner: shifts the memory word down to the accessed byte lane and
// sign/zero-extends per funct3; also reports natural-alignment violations.
module load_data_aligner
    import riscv_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int OFF_W     = $clog2(DATA_WIDTH / 8)
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [OFF_W-1:0]      offset,
    input  logic [2:0]            load_type,
    output logic [DATA_WIDTH-1:0] aligned,
    output logic                  misaligned
);

    logic [DATA_WIDTH-1:0] shifted;

    assign shifted = data >> {offset, 3'b000};

    always_comb begin
        aligned    = '0;
        misaligned = 1'b0;
        case (load_type)
            F3_LB:  aligned = DATA_WIDTH'($signed(shifted[7:0]));
            F3_LBU: aligned = DATA_WIDTH'(shifted[7:0]);
            F3_LH: begin
                aligned    = DATA_WIDTH'($signed(shifted[15:0]));
                misaligned = offset[0];
            end
            F3_LHU: begin
                aligned    = DATA_WIDTH'(shifted[15:0]);
                misaligned = offset[0];
            end
            F3_LW: begin
                aligned    = DATA_WIDTH'($signed(shifted[31:0]));
                misaligned = (offset[1:0] != 2'b00);
            end
            // LWU and LD only exist on RV64; on RV32 they decode to nothing.
            F3_LWU: begin
                if (DATA_WIDTH == 64) begin
                    aligned    = DATA_WIDTH'(shifted[31:0]);
                    misaligned = (offset[1:0] != 2'b00);
                end
            end
            F3_LD: begin
                if (DATA_WIDTH == 64) begin
                    aligned    = shifted;
                    misaligned = (offset != '0);
                end
            end
            default: aligned = '0;
        endcase
    end

endmodule

// File: rtl/write_back_stage_pipelined.sv
// MEM/WB stage register with registered-select write-back mux, load alignment,
// stall/flush control and a retired-instruction counter.
module write_back_stage_pipelined
    import riscv_wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int WB_SEL_WIDTH   = 2,
    parameter int INSTRET_WIDTH  = 64
) (
    input logic                         CLK,
    input logic                         RESET_N,
    write_back_stage_pipelined_if.slave wb
);

    localparam int OFF_W = $clog2(DATA_WIDTH / 8);

    logic                      valid_q, valid_d;
    logic                      fresh_q, fresh_d;
    logic                      reg_write_q, reg_write_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [WB_SEL_WIDTH-1:0]   wb_sel_q, wb_sel_d;
    logic [2:0]                load_type_q, load_type_d;
    logic [OFF_W-1:0]          byte_offset_q, byte_offset_d;
    logic [DATA_WIDTH-1:0]     alu_q, alu_d;
    logic [DATA_WIDTH-1:0]     mem_q, mem_d;
    logic [DATA_WIDTH-1:0]     pc4_q, pc4_d;
    logic [DATA_WIDTH-1:0]     csr_q, csr_d;
    logic [INSTRET_WIDTH-1:0]  instret_q, instret_d;

    logic                      capture;
    logic                      retire;
    logic                      is_load;
    logic                      load_mis;
    logic                      misaligned;
    logic [DATA_WIDTH-1:0]     load_data;
    logic [DATA_WIDTH-1:0]     rd_data;

    assign capture = ~wb.STALL;
    assign retire  = valid_q & fresh_q;

    always_comb begin
        reg_write_d   = reg_write_q;
        rd_addr_d     = rd_addr_q;
        wb_sel_d      = wb_sel_q;
        load_type_d   = load_type_q;
        byte_offset_d = byte_offset_q;
        alu_d         = alu_q;
        mem_d         = mem_q;
        pc4_d         = pc4_q;
        csr_d         = csr_q;
        if (capture) begin
            reg_write_d   = wb.REG_WRITE_IN;
            rd_addr_d     = wb.RD_ADDR_IN;
            wb_sel_d      = wb.WB_SEL_IN;
            load_type_d   = wb.LOAD_TYPE_IN;
            byte_offset_d = wb.BYTE_OFFSET_IN;
            alu_d         = wb.ALU_RESULT_IN;
            mem_d         = wb.MEM_DATA_IN;
            pc4_d         = wb.PC_PLUS_4_IN;
            csr_d         = wb.CSR_DATA_IN;
        end
        // FLUSH wins over STALL: a held instruction is dropped even while stalled.
        valid_d   = capture ? (wb.VALID_IN & ~wb.FLUSH) : (valid_q & ~wb.FLUSH);
        // Fresh marks the first cycle an instruction sits here so it retires once.
        fresh_d   = capture & wb.VALID_IN & ~wb.FLUSH;
        instret_d = instret_q + INSTRET_WIDTH'(retire);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_q       <= 1'b0;
            fresh_q       <= 1'b0;
            reg_write_q   <= 1'b0;
            rd_addr_q     <= '0;
            wb_sel_q      <= '0;
            load_type_q   <= '0;
            byte_offset_q <= '0;
            alu_q         <= '0;
            mem_q         <= '0;
            pc4_q         <= '0;
            csr_q         <= '0;
            instret_q     <= '0;
        end else begin
            valid_q       <= valid_d;
            fresh_q       <= fresh_d;
            reg_write_q   <= reg_write_d;
            rd_addr_q     <= rd_addr_d;
            wb_sel_q      <= wb_sel_d;
            load_type_q   <= load_type_d;
            byte_offset_q <= byte_offset_d;
            alu_q         <= alu_d;
            mem_q         <= mem_d;
            pc4_q         <= pc4_d;
            csr_q         <= csr_d;
            instret_q     <= instret_d;
        end
    end

    load_data_aligner #(.DATA_WIDTH(DATA_WIDTH)) u_aligner (
        .data       (mem_q),
        .offset     (byte_offset_q),
        .load_type  (load_type_q),
        .aligned    (load_data),
        .misaligned (load_mis)
    );

    // Unused select codes beyond CSR write zero.
    always_comb begin
        rd_data = '0;
        if (wb_sel_q == WB_SEL_WIDTH'(WB_ALU))       rd_data = alu_q;
        else if (wb_sel_q == WB_SEL_WIDTH'(WB_LOAD)) rd_data = load_data;
        else if (wb_sel_q == WB_SEL_WIDTH'(WB_PC4))  rd_data = pc4_q;
        else if (wb_sel_q == WB_SEL_WIDTH'(WB_CSR))  rd_data = csr_q;
    end

    assign is_load    = (wb_sel_q == WB_SEL_WIDTH'(WB_LOAD));
    assign misaligned = valid_q & is_load & load_mis;

    assign wb.RD_WRITE_EN_OUT = valid_q & reg_write_q & (rd_addr_q != '0) & ~misaligned;
    assign wb.RD_ADDR_OUT     = rd_addr_q;
    assign wb.RD_DATA_OUT     = rd_data;
    assign wb.VALID_OUT       = valid_q;
    assign wb.RETIRE_OUT      = retire;
    assign wb.MISALIGNED_OUT  = misaligned;
    assign wb.INSTRET_OUT     = instret_q;

endmodule

// File: tb/tb_write_back_stage_pipelined.sv
// Directed bench for write_back_stage_pipelined; a 4-bit retire counter makes the wrap reachable.
module tb_write_back_stage_pipelined;
    import riscv_wb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SW = 2;
    localparam int IW = 4;

    logic CLK;
    logic RESET_N;

    int checks = 0;
    int errors = 0;
    logic [IW-1:0] exp_cnt = '0;
    logic          last_ret = 1'b0;

    write_back_stage_pipelined_if #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .WB_SEL_WIDTH(SW), .INSTRET_WIDTH(IW)
    ) wb_if ();

    write_back_stage_pipelined #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .WB_SEL_WIDTH(SW), .INSTRET_WIDTH(IW)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .wb      (wb_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic vld, input logic we,
                              input logic [AW-1:0] rd, input logic [DW-1:0] data,
                              input logic ret, input logic mis);
        chk({tag, "_vld"},  64'(wb_if.VALID_OUT),       64'(vld));
        chk({tag, "_we"},   64'(wb_if.RD_WRITE_EN_OUT), 64'(we));
        chk({tag, "_rd"},   64'(wb_if.RD_ADDR_OUT),     64'(rd));
        chk({tag, "_data"}, 64'(wb_if.RD_DATA_OUT),     64'(data));
        chk({tag, "_ret"},  64'(wb_if.RETIRE_OUT),      64'(ret));
        chk({tag, "_mis"},  64'(wb_if.MISALIGNED_OUT),  64'(mis));
        chk({tag, "_cnt"},  64'(wb_if.INSTRET_OUT),     64'(exp_cnt));
        last_ret = ret;
    endtask

    task automatic drive(input logic vld, input logic rw, input logic [AW-1:0] rd,
                         input logic [SW-1:0] sel, input logic [2:0] lt, input logic [1:0] off,
                         input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                         input logic [DW-1:0] pc4, input logic [DW-1:0] csr);
        wb_if.VALID_IN       = vld;
        wb_if.REG_WRITE_IN   = rw;
        wb_if.RD_ADDR_IN     = rd;
        wb_if.WB_SEL_IN      = sel;
        wb_if.LOAD_TYPE_IN   = lt;
        wb_if.BYTE_OFFSET_IN = off;
        wb_if.ALU_RESULT_IN  = alu;
        wb_if.MEM_DATA_IN    = mem;
        wb_if.PC_PLUS_4_IN   = pc4;
        wb_if.CSR_DATA_IN    = csr;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (last_ret) exp_cnt = exp_cnt + 1'b1;
        #1;
    endtask

    initial begin
        RESET_N     = 1'b0;
        wb_if.STALL = 1'b0;
        wb_if.FLUSH = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        expect_out("rst", 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Reset mid-stream
        drive(1, 1, 3, 2'(WB_ALU), 0, 0, 32'h11, 0, 0, 0);
        tick();
        expect_out("pre_rst", 1, 1, 3, 32'h11, 1, 0);
        #2;
        RESET_N = 1'b0;
        exp_cnt = '0;
        last_ret = 1'b0;
        #1;
        expect_out("mid_rst", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
        expect_out("post_rst", 0, 0, 0, 0, 0, 0);

        // Load alignment / extension
        drive(1, 1, 5, 2'(WB_LOAD), F3_LB, 2, 0, 32'h80FF7F01, 0, 0);
        tick();
        expect_out("lb", 1, 1, 5, 32'hFFFFFFFF, 1, 0);
        drive(1, 1, 5, 2'(WB_LOAD), F3_LBU, 2, 0, 32'h80FF7F01, 0, 0);
        tick();
        expect_out("lbu", 1, 1, 5, 32'h000000FF, 1, 0);
        drive(1, 1, 5, 2'(WB_LOAD), F3_LH, 2, 0, 32'h80FF7F01, 0, 0);
        tick();
        expect_out("lh", 1, 1, 5, 32'hFFFF80FF, 1, 0);

        // Misaligned loads
        drive(1, 1, 6, 2'(WB_LOAD), F3_LW, 1, 0, 32'h80FF7F01, 0, 0);
        tick();
        expect_out("lw_mis", 1, 0, 6, 32'h0080FF7F, 1, 1);
        drive(1, 1, 6, 2'(WB_LOAD), F3_LH, 1, 0, 32'h80FF7F01, 0, 0);
        tick();
        expect_out("lh_mis", 1, 0, 6, 32'hFFFFFF7F, 1, 1);

        // x0 suppression and PC+4 source
        drive(1, 1, 0, 2'(WB_ALU), 0, 0, 32'h1234, 0, 0, 0);
        tick();
        expect_out("x0", 1, 0, 0, 32'h1234, 1, 0);
        drive(1, 1, 7, 2'(WB_PC4), 0, 0, 32'h1234, 0, 32'h104, 0);
        tick();
        expect_out("pc4", 1, 1, 7, 32'h104, 1, 0);

        // Stall hold for 3 cycles, then flush while stalled
        drive(1, 1, 9, 2'(WB_CSR), 0, 0, 0, 0, 0, 32'hCAFE0001);
        tick();
        expect_out("csr", 1, 1, 9, 32'hCAFE0001, 1, 0);
        wb_if.STALL = 1'b1;
        drive(1, 1, 12, 2'(WB_ALU), 0, 0, 32'hDEAD, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("stall%0d", i), 1, 1, 9, 32'hCAFE0001, 0, 0);
        end
        wb_if.FLUSH = 1'b1;
        tick();
        expect_out("flush", 0, 0, 9, 32'hCAFE0001, 0, 0);
        wb_if.STALL = 1'b0;
        wb_if.FLUSH = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("idle", 0, 0, 0, 0, 0, 0);
        chk("cnt_before_burst", 64'(wb_if.INSTRET_OUT), 64'd8);

        // 10 back-to-back retires, counter wraps past 15
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, AW'(i + 1), 2'(WB_ALU), 0, 0, DW'(i * 3 + 1), 0, 0, 0);
            tick();
            expect_out($sformatf("b2b%0d", i), 1, 1, AW'(i + 1), DW'(i * 3 + 1), 1, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("end", 0, 0, 0, 0, 0, 0);
        chk("cnt_wrap", 64'(wb_if.INSTRET_OUT), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
